// File: rtl/clk_sw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : clk_sw_pkg                                                   |
// | Purpose   : Shared types and constants for the clock-select controller.  |
// |             Holds the FSM state encoding, select-value constants and a   |
// |             counter-width helper.                                        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package clk_sw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_t;

  localparam logic SEL_CLK_A = 1'b0;
  localparam logic SEL_CLK_B = 1'b1;

  // Width of a counter that must hold values up to v-1, never below 1 bit.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_b_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : clk_b_monitor                                                |
// | Purpose   : clk_B liveness monitor. A clk_B toggle flop is synchronised  |
// |             into clk_A; its transitions are counted over a free-running  |
// |             window and b_alive is refreshed at every window end.         |
// | Ports     : clk_A, rstn_A  - control clock / async active-low reset      |
// |             clk_B, rstn_B  - monitored clock / reset of its toggle flop  |
// |             b_alive        - registered liveness status (clk_A domain)   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module clk_b_monitor
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_CYC     = 64,
  parameter int MIN_EDGES   = 4
) (
  input  logic clk_A,
  input  logic rstn_A,
  input  logic clk_B,
  input  logic rstn_B,
  output logic b_alive
);

  localparam int c_WIN_W  = cnt_width(WIN_CYC);
  // The edge count has to reach MIN_EDGES itself, hence one extra value.
  localparam int c_EDGE_W = cnt_width(MIN_EDGES + 1);

  localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(WIN_CYC - 1);
  localparam logic [c_WIN_W-1:0]  c_WIN_ONE  = c_WIN_W'(1);
  localparam logic [c_EDGE_W-1:0] c_EDGE_MAX = c_EDGE_W'(MIN_EDGES);
  localparam logic [c_EDGE_W-1:0] c_EDGE_ONE = c_EDGE_W'(1);

  logic                   r_tgl_b;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic [c_WIN_W-1:0]     r_win;
  logic [c_EDGE_W-1:0]    r_edges;
  logic                   w_edge;
  logic                   w_win_tc;

  // The only logic clocked by clk_B.
  always_ff @(posedge clk_B or negedge rstn_B) begin
    if (!rstn_B) r_tgl_b <= 1'b0;
    else         r_tgl_b <= ~r_tgl_b;
  end

  always_ff @(posedge clk_A or negedge rstn_A) begin
    if (!rstn_A) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], r_tgl_b};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge   = r_sync[SYNC_STAGES-1] ^ r_sync_d;
  assign w_win_tc = (r_win == c_WIN_LAST);

  always_ff @(posedge clk_A or negedge rstn_A) begin
    if (!rstn_A) begin
      r_win   <= '0;
      r_edges <= '0;
      b_alive <= 1'b0;
    end else if (w_win_tc) begin
      r_win   <= '0;
      b_alive <= (r_edges >= c_EDGE_MAX);
      // A transition landing on the window end belongs to the new window.
      r_edges <= w_edge ? c_EDGE_ONE : '0;
    end else begin
      r_win <= r_win + c_WIN_ONE;
      if (w_edge && (r_edges != c_EDGE_MAX)) r_edges <= r_edges + c_EDGE_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : clk_sel_ctrl                                                 |
// | Purpose   : Control stage in front of the glitch-free clock switch.      |
// |             Accepts select requests (valid/ready), confirms clk_B is     |
// |             alive before selecting it, waits for the switch to settle,   |
// |             reports done/error and enforces a dwell before the next one. |
// | Ports     : clk_A, rstn_A       - control clock / async active-low reset |
// |             clk_B, rstn_B       - monitored clock / its toggle reset     |
// |             req_valid, req_sel  - request handshake in (0=clk_A,1=clk_B) |
// |             req_ready           - high only when idle                    |
// |             sel                 - registered select to the switch        |
// |             cur_sel             - confirmed selection                    |
// |             sw_done, sw_err     - one-cycle completion / refusal pulses  |
// |             b_alive             - clk_B liveness status                  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module clk_sel_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_CYC     = 64,
  parameter int MIN_EDGES   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int DWELL_CYC   = 16
) (
  input  logic clk_A,
  input  logic rstn_A,
  input  logic clk_B,
  input  logic rstn_B,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic cur_sel,
  output logic sw_done,
  output logic sw_err,
  output logic b_alive
);

  // One counter serves both the settle and the dwell phase.
  localparam int c_CNT_W = cnt_width((SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_DWELL_LOAD  = c_CNT_W'(DWELL_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               w_sel_nxt, w_cur_nxt, w_done_nxt, w_err_nxt;

  clk_b_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIN_CYC     (WIN_CYC),
    .MIN_EDGES   (MIN_EDGES)
  ) u_mon (
    .clk_A   (clk_A),
    .rstn_A  (rstn_A),
    .clk_B   (clk_B),
    .rstn_B  (rstn_B),
    .b_alive (b_alive)
  );

  assign req_ready = (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = sel;
    w_cur_nxt   = cur_sel;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_sel) begin
            w_done_nxt = 1'b1;             // already there: complete immediately
          end else if (req_sel == SEL_CLK_B) begin
            w_state_nxt = CHECK;           // clk_B must be proven alive first
          end else begin
            w_sel_nxt   = SEL_CLK_A;       // clk_A is always running
            w_cnt_nxt   = c_SETTLE_LOAD;
            w_state_nxt = SETTLE;
          end
        end
      end
      CHECK: begin
        if (b_alive) begin
          w_sel_nxt   = SEL_CLK_B;
          w_cnt_nxt   = c_SETTLE_LOAD;
          w_state_nxt = SETTLE;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_cur_nxt   = sel;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = c_DWELL_LOAD;
          w_state_nxt = DWELL;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      DWELL: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - c_CNT_ONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_A or negedge rstn_A) begin
    if (!rstn_A) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      sel     <= SEL_CLK_A;
      cur_sel <= SEL_CLK_A;
      sw_done <= 1'b0;
      sw_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      sel     <= w_sel_nxt;
      cur_sel <= w_cur_nxt;
      sw_done <= w_done_nxt;
      sw_err  <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_clk_sel_ctrl                                              |
// | Purpose   : Self-checking bench for clk_sel_ctrl. A timestamp-based      |
// |             reference model predicts every output each clk_A cycle;      |
// |             directed sequences pin key latencies with literal values.    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clk_sel_ctrl;

  localparam int SYNC   = 2;
  localparam int WIN    = 64;
  localparam int MINE   = 4;
  localparam int SETTLE = 8;
  localparam int DWELL  = 16;
  localparam int MAXN   = 8192;
  localparam int NEVER  = 32'h7fff_ffff;

  logic clk_A = 1'b0, clk_B = 1'b0, b_run = 1'b0;
  logic rstn_A = 1'b1, rstn_B = 1'b0;
  logic req_valid = 1'b0, req_sel = 1'b0;
  logic req_ready, sel, cur_sel, sw_done, sw_err, b_alive;

  int n_checks = 0;
  int n_fail   = 0;

  clk_sel_ctrl #(
    .SYNC_STAGES (SYNC), .WIN_CYC (WIN), .MIN_EDGES (MINE),
    .SETTLE_CYC (SETTLE), .DWELL_CYC (DWELL)
  ) dut (
    .clk_A (clk_A), .rstn_A (rstn_A), .clk_B (clk_B), .rstn_B (rstn_B),
    .req_valid (req_valid), .req_sel (req_sel), .req_ready (req_ready),
    .sel (sel), .cur_sel (cur_sel), .sw_done (sw_done), .sw_err (sw_err),
    .b_alive (b_alive)
  );

  // clk_A period 20 (posedges at 10 mod 20); clk_B period 50 (2.5x slower).
  // clk_B toggles land on 3/8/13/18 mod 20, never on a clk_A edge.
  always #10 clk_A = ~clk_A;
  initial begin
    #3;
    forever #25 if (b_run) clk_B = ~clk_B;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic m_tgl;
  always @(posedge clk_B or negedge rstn_B)
    if (!rstn_B) m_tgl <= 1'b0;
    else         m_tgl <= ~m_tgl;

  bit hist [MAXN];
  bit flg  [MAXN];
  int n_cyc = 0;
  int done_at, chk_at, idle_at;
  bit m_sel, m_cur, m_done, m_err, m_ready, m_alive;

  function automatic bit hist_at(input int k);
    return (k <= 0) ? 1'b0 : hist[k];
  endfunction

  function automatic void model_reset();
    n_cyc = 0; m_sel = 0; m_cur = 0; m_done = 0; m_err = 0;
    m_ready = 1; m_alive = 0; done_at = -1; chk_at = -1; idle_at = 0;
  endfunction

  // Outputs after edge n: a sel change at edge e completes at e+SETTLE and
  // the block is idle again from e+SETTLE+DWELL; liveness is the number of
  // synchronised toggle changes over the 64 edges ending before a window end.
  always @(posedge clk_A) begin : p_model
    bit rdy_prev, cur_prev;
    int s;
    if (!rstn_A) model_reset();
    else if (n_cyc < MAXN - 1) begin
      rdy_prev = m_ready;
      cur_prev = m_cur;
      n_cyc    = n_cyc + 1;
      hist[n_cyc] = m_tgl;
      flg[n_cyc]  = hist_at(n_cyc - SYNC) ^ hist_at(n_cyc - SYNC - 1);
      m_done = 0;
      m_err  = 0;
      if (chk_at == n_cyc) begin
        chk_at = -1;
        if (m_alive) begin
          m_sel = 1; done_at = n_cyc + SETTLE; idle_at = n_cyc + SETTLE + DWELL;
        end else begin
          m_err = 1; idle_at = n_cyc;
        end
      end
      if (done_at == n_cyc) begin
        m_done = 1; m_cur = m_sel; done_at = -1;
      end
      if (req_valid && rdy_prev) begin
        if (req_sel == cur_prev) m_done = 1;
        else if (req_sel) begin
          chk_at = n_cyc + 1; idle_at = NEVER;
        end else begin
          m_sel = 0; done_at = n_cyc + SETTLE; idle_at = n_cyc + SETTLE + DWELL;
        end
      end
      m_ready = (n_cyc >= idle_at);
      if (n_cyc % WIN == 0) begin
        s = 0;
        for (int k = n_cyc - WIN; k < n_cyc; k++) if (k >= 1) s += int'(flg[k]);
        m_alive = (s >= MINE);
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk_A) begin
    if (!rstn_A) begin
      chk("rst_ready", req_ready, 1); chk("rst_sel", sel, 0); chk("rst_cur", cur_sel, 0);
      chk("rst_done", sw_done, 0);    chk("rst_err", sw_err, 0); chk("rst_alive", b_alive, 0);
    end else begin
      chk("req_ready", req_ready, m_ready); chk("sel", sel, m_sel);
      chk("cur_sel", cur_sel, m_cur);       chk("sw_done", sw_done, m_done);
      chk("sw_err", sw_err, m_err);         chk("b_alive", b_alive, m_alive);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_n(input int target);
    for (int k = 0; k < 5000 && n_cyc < target; k++) @(negedge clk_A);
    if (n_cyc < target) chk("wait_timeout", n_cyc, target);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200 && !req_ready; k++) @(negedge clk_A);
    chk("ready_timeout", req_ready, 1);
  endtask

  task automatic wait_phase30();
    for (int k = 0; k < 70 && (n_cyc % WIN) != 30; k++) @(negedge clk_A);
  endtask

  // Holds the request until it is taken; acc is the accepting edge number.
  task automatic do_req(input logic s, output int acc);
    logic r;
    acc = -1;
    req_valid = 1'b1;
    req_sel   = s;
    for (int k = 0; k < 200; k++) begin
      r = req_ready;
      @(negedge clk_A);
      if (r) begin acc = n_cyc; break; end
    end
    req_valid = 1'b0;
    if (acc < 0) chk("req_timeout", 0, 1);
  endtask

  initial begin : p_watchdog
    #(20 * 60000);
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int a, b, c, acc4, acc5, e;

    // Epoch 1: clk_B held still -> never alive.
    #1 rstn_A = 1'b0;
    repeat (3) @(negedge clk_A);
    rstn_A = 1'b1; rstn_B = 1'b1;
    @(negedge clk_A);
    chk("s1_sel", sel, 0); chk("s1_cur", cur_sel, 0); chk("s1_ready", req_ready, 1);
    wait_n(70);
    chk("s1_alive_held", b_alive, 0);

    // Epoch 2: clk_B running from reset.
    rstn_A = 1'b0; rstn_B = 1'b0; b_run = 1'b1;
    repeat (2) @(negedge clk_A);
    rstn_A = 1'b1; rstn_B = 1'b1;
    wait_n(63);
    chk("s1_alive_w0", b_alive, 0);
    wait_n(64);
    chk("s1_alive_w1", b_alive, 1);

    // A -> B
    wait_n(70);
    do_req(1'b1, a);
    chk("s2_check_sel", sel, 0);
    wait_n(a + 1);
    chk("s2_sel", sel, 1); chk("s2_ready", req_ready, 0);
    wait_n(a + 8);
    chk("s2_done_early", sw_done, 0);
    wait_n(a + 9);
    chk("s2_done", sw_done, 1); chk("s2_cur", cur_sel, 1);

    // B -> B held through dwell: no-op on the first idle cycle.
    do_req(1'b1, acc4);
    chk("s2_dwell_len", acc4, a + 1 + SETTLE + DWELL + 1);
    chk("s4_done", sw_done, 1); chk("s4_sel", sel, 1); chk("s4_ready", req_ready, 1);

    // B -> A, then A -> B, then B -> A requested during dwell.
    do_req(1'b0, b);
    do_req(1'b1, c);
    wait_n(c + 10);
    do_req(1'b0, acc5);
    chk("s5_first_idle", acc5, c + 1 + SETTLE + DWELL + 1);
    chk("s5_sel", sel, 0);
    wait_n(acc5 + 8);
    chk("s5_done", sw_done, 1); chk("s5_cur", cur_sel, 0);

    // clk_B stopped -> request refused.
    wait_ready();
    wait_phase30();
    b_run = 1'b0;
    wait_n(n_cyc + 140);
    chk("s3_alive", b_alive, 0);
    do_req(1'b1, e);
    chk("s3_err_early", sw_err, 0);
    wait_n(e + 1);
    chk("s3_err", sw_err, 1); chk("s3_sel", sel, 0);
    wait_n(e + 2);
    chk("s3_err_end", sw_err, 0); chk("s3_nodone", sw_done, 0);
    wait_phase30();
    b_run = 1'b1;

    // Random traffic with clk_B starting/stopping mid-window.
    for (int i = 0; i < 1500; i++) begin
      if ((n_cyc % WIN) == 30 && $urandom_range(0, 3) == 0) b_run = ~b_run;
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = 1'($urandom_range(0, 1));
      @(negedge clk_A);
    end
    req_valid = 1'b0;
    wait_phase30();
    b_run = 1'b1;

    // Reset in the middle of an A -> B settle.
    wait_ready();
    do_req(1'b0, e);
    wait_ready();
    wait_n(n_cyc + 140);
    do_req(1'b1, e);
    wait_n(e + 4);
    chk("s6_sel_pre", sel, 1);
    @(posedge clk_A);
    #4 rstn_A = 1'b0;
    #1;
    chk("s6_sel_async", sel, 0); chk("s6_cur_async", cur_sel, 0);
    @(negedge clk_A);
    @(negedge clk_A);
    rstn_A = 1'b1;
    wait_n(66);
    do_req(1'b1, e);
    wait_n(e + 1 + SETTLE);
    chk("s6_done", sw_done, 1); chk("s6_cur", cur_sel, 1);
    wait_n(e + 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
